// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/SHIFT, iterative shift-add
// MUL and restoring DIV that each take exactly WIDTH cycles.
module multicycle_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [2:0]       Alu_Opcode,
  input  logic             Shift,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero_Out,
  output logic             Carry_Out,
  output logic             Overflow,
  output logic             Div_By_Zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // hi/lo form a shared working pair: partial product + multiplier for MUL,
  // partial remainder + dividend/quotient for DIV.
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               div_op_q, div_op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     div_hi;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;

  // Single-cycle datapath, evaluated on the live inputs at the Start edge
  always_comb begin
    add_sum   = {1'b0, Operand1} + {1'b0, Operand2};
    sub_diff  = {1'b0, Operand1} - {1'b0, Operand2};
    shamt     = Operand2[SHAMT_W-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (Alu_Opcode)
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != Operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_ovf   = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != Operand1[WIDTH-1]);
      end
      OP_AND:   alu_res = Operand1 & Operand2;
      OP_OR:    alu_res = Operand1 | Operand2;
      OP_XOR:   alu_res = Operand1 ^ Operand2;
      OP_SHIFT: alu_res = Shift ? (Operand1 >> shamt) : (Operand1 << shamt);
      default:  alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = lo_q[0] ? (hi_q + {1'b0, op2_q}) : hi_q;
    mul_hi    = {1'b0, mul_sum[WIDTH:1]};
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op2_q};
    // A negative trial difference means the divisor did not fit: restore.
    div_hi    = div_diff[WIDTH] ? div_shift : div_diff;
    div_lo    = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    step_hi   = div_op_q ? div_hi : mul_hi;
    step_lo   = div_op_q ? div_lo : mul_lo;
  end

  // Control FSM; results and flags only change on the transition into DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op2_d    = op2_q;
    div_op_d = div_op_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          hi_d     = '0;
          lo_d     = Operand1;
          op2_d    = Operand2;
          div_op_d = Alu_Opcode[0];
          cnt_d    = '0;
          if (Alu_Opcode[2:1] == 2'b11) begin
            state_d = ST_CALC;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            dbz_d    = 1'b0;
          end
        end
      end
      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // A zero divisor naturally yields an all-ones quotient.
          state_d  = ST_DONE;
          result_d = step_lo;
          zero_d   = (step_lo == '0);
          carry_d  = 1'b0;
          ovf_d    = div_op_q ? 1'b0 : (step_hi[WIDTH-1:0] != '0);
          dbz_d    = div_op_q && (op2_q == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op2_q    <= '0;
      div_op_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op2_q    <= op2_d;
      div_op_q <= div_op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy        = (state_q == ST_CALC);
  assign Done        = (state_q == ST_DONE);
  assign Result      = result_q;
  assign Zero_Out    = zero_q;
  assign Carry_Out   = carry_q;
  assign Overflow    = ovf_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver pushes model results,
// an independent monitor pops and compares on every Done pulse.
module tb_multicycle_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [2:0]   alu_opcode;
  logic         shift;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero_out;
  logic         carry_out;
  logic         overflow;
  logic         div_by_zero;

  multicycle_alu #(.WIDTH(W)) dut (
    .Clk         (clk),
    .Reset       (reset),
    .Start       (start),
    .Operand1    (operand1),
    .Operand2    (operand2),
    .Alu_Opcode  (alu_opcode),
    .Shift       (shift),
    .Busy        (busy),
    .Done        (done),
    .Result      (result),
    .Zero_Out    (zero_out),
    .Carry_Out   (carry_out),
    .Overflow    (overflow),
    .Div_By_Zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    logic         d;
    int           done_cyc;
    int           busy_len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_run = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time Done against the Start edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions of each opcode
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sh);
    exp_t   e;
    longint ua, ub, sa, sbv, t, half, full;
    int     amt;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    half = longint'(1) <<< (W - 1);
    full = longint'(1) <<< W;
    e.res = '0; e.c = 1'b0; e.o = 1'b0; e.d = 1'b0;
    e.done_cyc = 0; e.busy_len = 0;
    case (op)
      3'd0: begin
        t = ua + ub; e.res = W'(t); e.c = (t >= full);
        t = sa + sbv; e.o = (t >= half) || (t < -half);
      end
      3'd1: begin
        t = ua - ub; e.res = W'(t); e.c = (ua < ub);
        t = sa - sbv; e.o = (t >= half) || (t < -half);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        amt = int'(ub % W);
        e.res = sh ? W'(ua >> amt) : W'(ua << amt);
      end
      3'd6: begin
        t = ua * ub; e.res = W'(t); e.o = (t >= full); e.busy_len = W;
      end
      default: begin
        e.busy_len = W;
        if (ub == 0) begin e.res = '1; e.d = 1'b1; end
        else e.res = W'(ua / ub);
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Issue one operation at a negedge, scramble inputs while it runs, and
  // return at the earliest cycle a new Start may be accepted
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic sh, input logic hold);
    exp_t e;
    e = model(op, a, b, sh);
    e.done_cyc = cyc + 1 + e.busy_len;
    sb.push_back(e);
    start = 1'b1; operand1 = a; operand2 = b; alu_opcode = op; shift = sh;
    @(negedge clk);
    for (int i = 0; i <= e.busy_len; i++) begin
      start      = hold ? 1'b1 : 1'($urandom_range(0, 1));
      operand1   = W'($urandom);
      operand2   = W'($urandom);
      alu_opcode = 3'($urandom);
      shift      = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Monitor: compare every Done pulse with the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result",      result,      mon_e.res);
        checkOutput("zero_out",    zero_out,    mon_e.z);
        checkOutput("carry_out",   carry_out,   mon_e.c);
        checkOutput("overflow",    overflow,    mon_e.o);
        checkOutput("div_by_zero", div_by_zero, mon_e.d);
        checkOutput("done_cycle",  cyc,         mon_e.done_cyc);
        checkOutput("busy_len",    busy_run,    mon_e.busy_len);
        checkOutput("busy_at_done", busy,       1'b0);
      end
      busy_run = 0;
    end else if (busy === 1'b1) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Main stimulus sequence
  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    reset = 1'b1; start = 1'b0; operand1 = '0; operand2 = '0;
    alu_opcode = '0; shift = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   busy,        1'b0);
    checkOutput("rst_done",   done,        1'b0);
    checkOutput("rst_result", result,      '0);
    checkOutput("rst_zero",   zero_out,    1'b1);
    checkOutput("rst_carry",  carry_out,   1'b0);
    checkOutput("rst_ovf",    overflow,    1'b0);
    checkOutput("rst_dbz",    div_by_zero, 1'b0);
    reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(3'd1, 16'h0004, 16'h0004, 1'b0, 1'b0);
    applyStimulus(3'd1, 16'h0002, 16'h0004, 1'b0, 1'b0);
    applyStimulus(3'd5, 16'h0004, 16'h0002, 1'b1, 1'b0);
    applyStimulus(3'd5, 16'h0004, 16'h0002, 1'b0, 1'b0);
    applyStimulus(3'd5, 16'hA5A5, 16'h0000, 1'b1, 1'b0);
    applyStimulus(3'd6, 16'h0004, 16'h0002, 1'b0, 1'b0);
    applyStimulus(3'd6, 16'h0100, 16'h0100, 1'b0, 1'b0);
    applyStimulus(3'd7, 16'h0064, 16'h0007, 1'b0, 1'b0);
    applyStimulus(3'd7, 16'h0004, 16'h0000, 1'b0, 1'b0);
    applyStimulus(3'd2, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    applyStimulus(3'd7, 16'hFFFF, 16'h0001, 1'b0, 1'b0);

    $display("[TB] start held high through a multiply");
    applyStimulus(3'd6, 16'h0003, 16'h0005, 1'b0, 1'b1);

    $display("[TB] reset in the middle of a multiply");
    start = 1'b1; operand1 = 16'h1234; operand2 = 16'h0003;
    alu_opcode = 3'd6; shift = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",   busy,        1'b0);
    checkOutput("abort_done",   done,        1'b0);
    checkOutput("abort_result", result,      '0);
    checkOutput("abort_zero",   zero_out,    1'b1);
    checkOutput("abort_carry",  carry_out,   1'b0);
    checkOutput("abort_ovf",    overflow,    1'b0);
    checkOutput("abort_dbz",    div_by_zero, 1'b0);
    reset = 1'b0;
    applyStimulus(3'd0, 16'h0005, 16'h000A, 1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int k = 0; k < 200; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 20));
      applyStimulus(rop, ra, rb, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    start = 1'b0;
    repeat (W + 5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001: WIDTH, 16, operand and result width in bits; legal range 8 to 64, even values only.
REQ-002: SHAMT_W, $clog2(WIDTH), number of Operand2 LSBs used as the shift amount.
REQ-003: Clk  input  1  rising-edge clock for all state.
REQ-004: Reset  input  1  synchronous, active-high reset.
REQ-005: Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006: Operand1  input  WIDTH  first operand.
REQ-007: Operand2  input  WIDTH  second operand, or the shift amount.
REQ-008: Alu_Opcode  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHIFT, 110 MUL, 111 DIV.
REQ-009: Shift  input  1  shift direction for opcode 101: 0 = logical left, 1 = logical right.
REQ-010: Busy  output  1  high while an operation is in progress.
REQ-011: Done  output  1  single-cycle pulse when Result and the flags are valid.
REQ-012: Result  output  WIDTH  registered operation result.
REQ-013: Zero_Out  output  1  high when Result is all zeros.
REQ-014: Carry_Out  output  1  carry out for ADD; borrow for SUB; 0 for every other opcode.
REQ-015: Overflow  output  1  signed overflow for ADD/SUB; high half of the product nonzero for MUL; 0 otherwise.
REQ-016: Div_By_Zero  output  1  high when the last DIV had Operand2 equal to 0.

Function
REQ-017: The state machine SHALL have three states: IDLE, CALC, DONE.
REQ-018: In IDLE with Start=1, the block SHALL capture Operand1, Operand2, Alu_Opcode and Shift into internal registers.
- Opcodes 000-101 go to DONE.
- Opcodes 110-111 go to CALC, with Busy=1 and the iteration counter cleared.
REQ-019: Start SHALL be ignored in CALC and DONE; later input changes SHALL not affect the captured operands.
REQ-020: Single-cycle ops SHALL assert Done in cycle N+1 when Start is sampled in cycle N.
REQ-021: ADD/SUB SHALL compute WIDTH+1-bit sums.
- Carry_Out = bit WIDTH of the sum.
- Overflow = two's-complement sign overflow.
REQ-022: SHIFT SHALL shift Operand1 by Operand2[SHAMT_W-1:0], zero-filling; a shift amount of 0 returns Operand1 unchanged.
REQ-023: MUL SHALL be an unsigned iterative shift-add, one multiplier bit per cycle, for exactly WIDTH cycles in CALC.
- Result = low WIDTH bits of the product.
REQ-024: DIV SHALL be an unsigned restoring divide, one quotient bit per cycle, for exactly WIDTH cycles in CALC.
- Result = quotient; the remainder is discarded.
REQ-025: DIV with Operand2=0 SHALL still take WIDTH cycles and SHALL produce Result all ones and Div_By_Zero=1.
REQ-026: Multi-cycle ops SHALL assert Done in cycle N+WIDTH+1.
- Busy SHALL be high from cycle N+1 through N+WIDTH.
REQ-027: DONE SHALL last one cycle with Done=1 and Busy=0, then return to IDLE.
- Start in the DONE cycle is ignored.
- The earliest next accepted Start is one cycle after Done.
REQ-028: Result and all flags SHALL update only on the cycle Done is asserted, and SHALL hold until the next Done or Reset.
REQ-029: Zero_Out SHALL be computed from the final Result for every opcode, including DIV by zero, where it is 0.
REQ-030: Div_By_Zero SHALL be cleared on any Done from a non-DIV op or from a DIV with a nonzero divisor.

Reset
REQ-031: Reset=1 at a clock edge SHALL force all of the following, overriding Start:
- state to IDLE;
- Busy=0 and Done=0;
- Result=0 and Zero_Out=1;
- Carry_Out=0, Overflow=0, Div_By_Zero=0;
- the iteration counter and internal registers cleared.
REQ-032: Reset asserted during CALC SHALL abort the operation with no Done pulse.
- A Start in the first cycle after Reset deasserts SHALL be accepted normally.

Verification (WIDTH=16)
REQ-033: ADD 0x7FFF + 0x0001 -> Result=0x8000, Overflow=1, Carry_Out=0, Zero_Out=0, Done 1 cycle after Start.
REQ-034: SUB 0x0004 - 0x0004 -> Result=0x0000, Zero_Out=1, Carry_Out=0; then SUB 0x0002 - 0x0004 -> Result=0xFFFE, Carry_Out=1.
REQ-035: SHIFT Operand1=0x0004, Operand2=0x0002, Shift=1 -> 0x0001; the same inputs with Shift=0 -> 0x0010.
REQ-036: MUL 0x0004 * 0x0002 -> Result=0x0008, Busy high exactly 16 cycles, Done at cycle N+17; MUL 0x0100 * 0x0100 -> Result=0x0000, Overflow=1, Zero_Out=1.
REQ-037: DIV 0x0064 / 0x0007 -> 0x000E; DIV 0x0004 / 0x0000 -> 0xFFFF, Div_By_Zero=1, Done at N+17.
REQ-038: Start held high throughout a MUL -> only one Done; Reset at cycle N+8 of a MUL -> no Done, Busy=0 and Result=0x0000 next cycle.
